// File: rtl/stream_padder.sv
// Byte-granular message padder: packs BWIDTH-bit words into IWIDTH-bit rate blocks,
// appends the pad marker after the last byte and zero-fills the remainder.
module stream_padder #(
    parameter int         IWIDTH   = 64,
    parameter int         BWIDTH   = 32,
    parameter int         PAD_MODE = 0,
    parameter logic [7:0] PAD_BYTE = 8'h80
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [BWIDTH-1:0]                in_data,
    input  logic                             in_last,
    input  logic [$clog2(BWIDTH/8+1)-1:0]    in_bytes,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [IWIDTH-1:0]                out_data,
    output logic                             out_last,
    output logic                             out_padded
);

    localparam int NB  = BWIDTH / 8;
    localparam int NW  = IWIDTH / BWIDTH;
    localparam int BCW = $clog2(NB + 1);
    localparam int WCW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [WCW-1:0] WLAST = WCW'(NW - 1);
    localparam logic [BCW-1:0] NBV   = BCW'(NB);

    typedef enum logic [1:0] {INIT, FILL, EMIT, PADBLK} state_t;

    state_t            state, state_nxt;
    logic [WCW-1:0]    wcnt, wcnt_nxt;
    logic              pend, pend_nxt;
    logic [IWIDTH-1:0] blk, blk_nxt;
    logic              in_ready_nxt, out_valid_nxt, out_last_nxt, out_padded_nxt;
    logic [BCW-1:0]    nb;
    logic              full;

    // Keeps bytes below n of a final word, drops the marker at byte n, zeroes the rest.
    function automatic logic [BWIDTH-1:0] pad_word(input logic [BWIDTH-1:0] d,
                                                   input logic lst,
                                                   input logic [BCW-1:0] n);
        logic [BWIDTH-1:0] w;
        w = '0;
        for (int j = 0; j < NB; j++) begin
            if (!lst || j < int'(n))
                w[8*j +: 8] = d[8*j +: 8];
            else if (j == int'(n))
                w[8*j +: 8] = PAD_BYTE;
        end
        return w;
    endfunction

    function automatic logic [IWIDTH-1:0] mark_last(input logic [IWIDTH-1:0] b);
        logic [IWIDTH-1:0] r;
        r = b;
        if (PAD_MODE == 1)
            r[IWIDTH-1] = 1'b1;
        return r;
    endfunction

    always_comb begin
        nb             = (in_bytes > NBV) ? NBV : in_bytes;
        full           = (nb == NBV);
        state_nxt      = state;
        wcnt_nxt       = wcnt;
        pend_nxt       = pend;
        blk_nxt        = blk;
        in_ready_nxt   = 1'b0;
        out_valid_nxt  = 1'b0;
        out_last_nxt   = out_last;
        out_padded_nxt = out_padded;

        case (state)
            INIT: begin
                state_nxt    = FILL;
                in_ready_nxt = 1'b1;
            end
            FILL: begin
                in_ready_nxt = 1'b1;
                if (in_valid && in_ready) begin
                    for (int k = 0; k < NW; k++) begin
                        if (k == int'(wcnt))
                            blk_nxt[k*BWIDTH +: BWIDTH] = pad_word(in_data, in_last, nb);
                        else if (in_last && k > int'(wcnt))
                            blk_nxt[k*BWIDTH +: BWIDTH] = (full && k == int'(wcnt) + 1)
                                                          ? BWIDTH'(PAD_BYTE) : '0;
                    end
                    if (!in_last && wcnt != WLAST) begin
                        wcnt_nxt = wcnt + WCW'(1);
                    end else begin
                        state_nxt      = EMIT;
                        in_ready_nxt   = 1'b0;
                        out_valid_nxt  = 1'b1;
                        out_last_nxt   = 1'b0;
                        out_padded_nxt = 1'b0;
                        // A block-aligned final word leaves no room; the marker goes in a follow-up block.
                        if (in_last && full && wcnt == WLAST) begin
                            pend_nxt = 1'b1;
                        end else if (in_last) begin
                            blk_nxt        = mark_last(blk_nxt);
                            out_last_nxt   = 1'b1;
                            out_padded_nxt = 1'b1;
                        end
                    end
                end
            end
            EMIT: begin
                out_valid_nxt = 1'b1;
                if (out_ready) begin
                    wcnt_nxt = '0;
                    if (pend) begin
                        state_nxt      = PADBLK;
                        blk_nxt        = mark_last(IWIDTH'(PAD_BYTE));
                        out_last_nxt   = 1'b1;
                        out_padded_nxt = 1'b1;
                    end else begin
                        state_nxt      = FILL;
                        blk_nxt        = '0;
                        out_valid_nxt  = 1'b0;
                        in_ready_nxt   = 1'b1;
                        out_last_nxt   = 1'b0;
                        out_padded_nxt = 1'b0;
                    end
                end
            end
            PADBLK: begin
                out_valid_nxt = 1'b1;
                if (out_ready) begin
                    state_nxt      = FILL;
                    pend_nxt       = 1'b0;
                    blk_nxt        = '0;
                    out_valid_nxt  = 1'b0;
                    in_ready_nxt   = 1'b1;
                    out_last_nxt   = 1'b0;
                    out_padded_nxt = 1'b0;
                end
            end
            default: state_nxt = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INIT;
            wcnt       <= '0;
            pend       <= 1'b0;
            blk        <= '0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_padded <= 1'b0;
        end else begin
            state      <= state_nxt;
            wcnt       <= wcnt_nxt;
            pend       <= pend_nxt;
            blk        <= blk_nxt;
            in_ready   <= in_ready_nxt;
            out_valid  <= out_valid_nxt;
            out_last   <= out_last_nxt;
            out_padded <= out_padded_nxt;
        end
    end

    assign out_data = blk;

endmodule
